dynamic_led_scan: RTL
=====================

Name: dynamic_led_scan

Overview:
- Parametrised multiplexed 7-segment display driver for the board-level display path.
- Scans DIGITS common-terminal digits using a prescaled time base.
- Hex-decodes each digit's nibble from a double-buffered data register that updates tear-free at frame boundaries.
- Adds brightness control (PWM within each digit slot), per-digit decimal point, leading-zero suppression, configurable output polarity and a frame-done pulse.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2, need not be a power of two)
PRE_W, 16, prescaler width; each digit slot lasts 2^PRE_W clocks
BRIGHT_W, 3, brightness code width (1 <= BRIGHT_W <= PRE_W)
SEG_ACT_LOW, 0, 1 = segment outputs active-low
SL_ACT_LOW, 1, 1 = digit selects active-low

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Dat_in  in  4*DIGITS  nibble i = hex value of digit i (digit 0 = least significant)
Dp_in  in  DIGITS  decimal point per digit, 1 = lit
Load  in  1  capture Dat_in/Dp_in into shadow register
Lz_suppress  in  1  1 = blank leading zeros
Brightness  in  BRIGHT_W  on-time code; 0 = dark
Seg  out  8  Seg[0..6] = segments a..g, Seg[7] = dp, polarity per SEG_ACT_LOW
Sl  out  DIGITS  one-hot digit select, polarity per SL_ACT_LOW
Frame_done  out  1  one-clock pulse at each frame wrap

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is Clk, reset port is Reset.
- Reset state:
  - prescaler = 0, digit index = 0.
  - Active and shadow registers = 0; pending = 0.
  - Seg = all inactive (0x00, or 0xFF if SEG_ACT_LOW).
  - Sl = all inactive.
  - Frame_done = 0.
  - Reset is honoured mid-scan and mid-load; any pending data is discarded.
- Prescaler: free-running, PRE_W bits. tick = (prescaler == all ones).
- Digit advance: on tick the digit index advances; DIGITS-1 wraps to 0.
- Frame boundary: tick with index == DIGITS-1. On that cycle Frame_done is registered high, so the pulse appears on the next cycle for exactly one clock.
- Double buffering:
  - Load = 1 copies Dat_in/Dp_in into shadow and sets pending.
  - At a frame boundary with pending = 1, shadow is copied to active and pending clears.
  - Load and frame boundary in the same cycle: Dat_in/Dp_in go directly into active and pending clears.
  - Repeated Load before a boundary: the last capture wins.
- Brightness: digit is enabled while prescaler[PRE_W-1 -: BRIGHT_W] < Brightness.
  - Brightness = 0 gives a fully dark display.
  - The maximum code gives a duty of (2^BRIGHT_W - 1)/2^BRIGHT_W; the guaranteed off tail at the end of each slot is the anti-ghosting gap.
  - Brightness is sampled continuously; a change takes effect within the current slot.
- Leading-zero suppression: digit i (i >= 1) is suppressed when Lz_suppress = 1 and nibbles DIGITS-1 down to i are all 0. Digit 0 is never suppressed. A suppressed digit drives segments a..g off but still drives dp.
- Decode: standard hex 0-F, with bit order g..a:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Outputs:
  - Seg and Sl are registered, one clock after the prescaler/index state they reflect.
  - When the digit is disabled (PWM off), Sl is all inactive and Seg is all inactive.
  - Polarity inversion is applied at the output register input.
  - At most one Sl bit is active in any cycle.

Decomposition:
- Shared package (led_pkg): 7-bit segment constant table SEG_HEX[16], index constants SEG_DP = 7 and SEG_A..SEG_G, function for the digit-index width (clog2 with minimum 1).
- One sub-module, seg7_hex_decode: combinational nibble + dp + blank -> 8-bit segment pattern (active-high). Polarity is handled in the top level.

Test Plan:
All scenarios use DIGITS=4, PRE_W=4, BRIGHT_W=2, SEG_ACT_LOW=0, SL_ACT_LOW=1.
1. Reset release, Brightness=3, no Load -> Sl = 1110 for prescaler 0..11 (seen on the following clocks) and 1111 for 12..15. Seg = 0x3F while on. Digit order 0,1,2,3. Frame_done pulses every 64 clocks.
2. Load Dat_in=0x12AF, Dp_in=0010 mid-frame -> display unchanged until the next Frame_done. Then digit0 Seg=0x71, digit1 Seg=0xF7 (A with dp), digit2 Seg=0x5B, digit3 Seg=0x06.
3. Load asserted exactly on the frame-boundary cycle with Dat_in=0x0008 -> the new value shows from digit 0 of the very next frame; no stale frame.
4. Dat_in=0x0050, Lz_suppress=1, Dp_in=1000 -> digit3 Seg=0x80 (dp only), digit2 Seg=0x00, digit1 Seg=0x6D, digit0 Seg=0x3F. Dat_in=0x0000 -> only digit0 shows 0x3F.
5. Brightness=0 -> Sl stays 1111 and Seg stays 0x00 for a full frame. Brightness=1 -> Sl is active for prescaler 0..3 only.
6. Reset asserted mid-slot with pending Load -> Sl=1111 and Seg=0x00 immediately (asynchronously). After release, active data = 0 and pending cleared; the display shows 0000.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the 7-segment display path: segment bit positions,
// the hex glyph table and the digit-index width helper.
package led_pkg;

  // Segment bit positions inside the 8-bit segment bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyphs 0..F, bit 6 = g down to bit 0 = a, active-high
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width of a digit index; never narrower than one bit
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder. Output is active-high; a blanked
// digit keeps its decimal point so dp-only digits remain possible.
module seg7_hex_decode
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [6:0] glyph_s;

  // Look up the glyph, force a..g off when blanked, then place every bit
  always_comb begin
    glyph_s = 7'h00;
    seg     = 8'h00;
    if (blank) begin
      glyph_s = 7'h00;
    end else begin
      glyph_s = SEG_HEX[nibble];
    end
    seg[SEG_A]  = glyph_s[0];
    seg[SEG_B]  = glyph_s[1];
    seg[SEG_C]  = glyph_s[2];
    seg[SEG_D]  = glyph_s[3];
    seg[SEG_E]  = glyph_s[4];
    seg[SEG_F]  = glyph_s[5];
    seg[SEG_G]  = glyph_s[6];
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/dynamic_led_scan.sv
// Multiplexed 7-segment display driver: prescaled digit scan, tear-free
// double-buffered data, PWM brightness, leading-zero blanking and
// configurable output polarity.
module dynamic_led_scan #(
  parameter int DIGITS      = 4,
  parameter int PRE_W       = 16,
  parameter int BRIGHT_W    = 3,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit SL_ACT_LOW  = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Dat_in,
  input  logic [DIGITS-1:0]     Dp_in,
  input  logic                  Load,
  input  logic                  Lz_suppress,
  input  logic [BRIGHT_W-1:0]   Brightness,
  output logic [7:0]            Seg,
  output logic [DIGITS-1:0]     Sl,
  output logic                  Frame_done
);

  import led_pkg::*;

  localparam int IDX_W = idx_width(DIGITS);
  localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SL_OFF  = SL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    prescaler_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] shadow_dat_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic                pending_r;
  logic [4*DIGITS-1:0] active_dat_r;
  logic [DIGITS-1:0]   active_dp_r;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   sl_r;
  logic                frame_done_r;

  logic                tick_s;
  logic                last_digit_s;
  logic                boundary_s;
  logic                pwm_on_s;
  logic [3:0]          nibble_s;
  logic                dp_s;
  logic                blank_s;
  logic                zero_run_s;
  logic [DIGITS-1:0]   sel_s;
  logic [7:0]          pattern_s;

  assign tick_s       = &prescaler_r;
  assign last_digit_s = (idx_r == IDX_W'(DIGITS - 1));
  assign boundary_s   = tick_s && last_digit_s;
  // The top code can never be below Brightness, so each slot ends dark
  assign pwm_on_s     = (prescaler_r[PRE_W-1 -: BRIGHT_W] < Brightness);

  // Free-running prescaler and digit index that advances on each tick
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescaler_r <= '0;
      idx_r       <= '0;
    end else begin
      prescaler_r <= prescaler_r + PRE_W'(1'b1);
      if (tick_s) begin
        idx_r <= last_digit_s ? '0 : idx_r + IDX_W'(1'b1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Double buffer: capture into shadow, promote to active only at frame wrap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_dat_r <= '0;
      shadow_dp_r  <= '0;
      pending_r    <= 1'b0;
      active_dat_r <= '0;
      active_dp_r  <= '0;
    end else if (Load && boundary_s) begin
      active_dat_r <= Dat_in;
      active_dp_r  <= Dp_in;
      pending_r    <= 1'b0;
    end else if (Load) begin
      shadow_dat_r <= Dat_in;
      shadow_dp_r  <= Dp_in;
      pending_r    <= 1'b1;
    end else if (boundary_s && pending_r) begin
      active_dat_r <= shadow_dat_r;
      active_dp_r  <= shadow_dp_r;
      pending_r    <= 1'b0;
    end else begin
      pending_r    <= pending_r;
    end
  end

  // Select the current digit's nibble/dp and decide leading-zero blanking
  always_comb begin
    nibble_s   = 4'h0;
    dp_s       = 1'b0;
    blank_s    = 1'b0;
    zero_run_s = 1'b1;
    sel_s      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (active_dat_r[4*i +: 4] == 4'h0);
      if (idx_r == IDX_W'(i)) begin
        nibble_s = active_dat_r[4*i +: 4];
        dp_s     = active_dp_r[i];
        sel_s[i] = 1'b1;
        blank_s  = Lz_suppress && zero_run_s && (i != 0);
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (nibble_s),
    .dp     (dp_s),
    .blank  (blank_s),
    .seg    (pattern_s)
  );

  // Registered outputs with polarity applied before the flop
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      seg_r        <= SEG_OFF;
      sl_r         <= SL_OFF;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;
      if (pwm_on_s) begin
        seg_r <= pattern_s ^ SEG_OFF;
        sl_r  <= sel_s ^ SL_OFF;
      end else begin
        seg_r <= SEG_OFF;
        sl_r  <= SL_OFF;
      end
    end
  end

  assign Seg        = seg_r;
  assign Sl         = sl_r;
  assign Frame_done = frame_done_r;

endmodule
